// File: rtl/z_run_mon_pkg.sv
// Shared types and default widths for the z run-length monitor.
package z_run_mon_pkg;

    localparam int unsigned CNT_W_DEF = 8;
    localparam int unsigned EVT_W_DEF = 16;

    typedef enum logic [0:0] {StIdle, StRun} run_state_e;

    // Default-width view of a run record, for consumers built at CNT_W_DEF.
    typedef struct packed {
        logic [CNT_W_DEF-1:0] len;
        logic                 sat;
    } run_rec_t;

endpackage

// File: rtl/z_run_monitor_if.sv
// Run-record output handshake: valid/ready with saturated length and overflow flag.
interface z_run_monitor_if
    import z_run_mon_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
);
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_len;
    logic             out_sat;

    modport master (output out_valid, output out_len, output out_sat, input out_ready);
    modport slave  (input out_valid, input out_len, input out_sat, output out_ready);
endinterface

// File: rtl/z_run_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; sat_o latches an increment attempted at full scale.
module sat_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [Width-1:0] cnt_o,
    output logic [Width-1:0] cnt_d_o,
    output logic             sat_o
);
    logic [Width-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;

    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (clr_i) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (inc_i) begin
            if (&cnt_q) begin
                sat_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign cnt_d_o = cnt_d;
    assign sat_o   = sat_q;
endmodule

// File: rtl/z_run_monitor.sv
// Measures runs of z=1 and emits one {len, sat} record per run; max_len exists only when
// Z_RUN_MON_MAX_EN is defined.
module z_run_monitor
    import z_run_mon_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned EVT_W  = EVT_W_DEF,
    parameter int unsigned THRESH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             z,
    input  logic             clear,
    z_run_monitor_if.master  out_if,
    output logic [EVT_W-1:0] run_cnt,
    output logic             alarm,
    output logic             drop
`ifdef Z_RUN_MON_MAX_EN
    ,
    output logic [CNT_W-1:0] max_len
`endif
);
    typedef struct packed {
        logic [CNT_W-1:0] len;
        logic             sat;
    } rec_t;

    run_state_e       state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             sat_q;
    logic             push, lost;
    logic             alarm_q, alarm_d;
    logic             out_valid_q, out_valid_d;
    rec_t             rec_q, rec_d;
    logic [EVT_W-1:0] run_cnt_q, run_cnt_d;
    logic             drop_q, drop_d;

    assign push = (state_q == StRun) && !z;

    sat_counter #(
        .Width (CNT_W)
    ) u_len (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (z),
        .clr_i   (push),
        .cnt_o   (len_q),
        .cnt_d_o (len_d),
        .sat_o   (sat_q)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (z)  state_d = StRun;
            StRun:   if (!z) state_d = StIdle;
            default: state_d = StIdle;
        endcase

        alarm_d = (state_d == StRun) && (32'(len_d) >= THRESH);

        // A held record is only replaced when the consumer takes it on this same edge.
        out_valid_d = out_valid_q;
        rec_d       = rec_q;
        lost        = 1'b0;
        if (push) begin
            if (!out_valid_q || out_if.out_ready) begin
                rec_d       = '{len: len_q, sat: sat_q};
                out_valid_d = 1'b1;
            end else begin
                lost = 1'b1;
            end
        end else if (out_if.out_ready) begin
            out_valid_d = 1'b0;
        end

        run_cnt_d = clear ? '0 : run_cnt_q + EVT_W'(push);
        drop_d    = !clear && (drop_q || lost);
    end

`ifdef Z_RUN_MON_MAX_EN
    logic [CNT_W-1:0] max_len_q, max_len_d;

    always_comb begin
        max_len_d = max_len_q;
        if (clear) begin
            max_len_d = '0;
        end else if (push && (len_q > max_len_q)) begin
            max_len_d = len_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) max_len_q <= '0;
        else     max_len_q <= max_len_d;
    end

    assign max_len = max_len_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            alarm_q     <= 1'b0;
            out_valid_q <= 1'b0;
            rec_q       <= '0;
            run_cnt_q   <= '0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            alarm_q     <= alarm_d;
            out_valid_q <= out_valid_d;
            rec_q       <= rec_d;
            run_cnt_q   <= run_cnt_d;
            drop_q      <= drop_d;
        end
    end

    assign out_if.out_valid = out_valid_q;
    assign out_if.out_len   = rec_q.len;
    assign out_if.out_sat   = rec_q.sat;
    assign run_cnt          = run_cnt_q;
    assign alarm            = alarm_q;
    assign drop             = drop_q;
endmodule

// File: tb/tb_z_run_monitor.sv
// Bench for z_run_monitor: two CNT_W=4 instances (THRESH 5 and 16) against a run-length model.
module tb_z_run_monitor;
    localparam int CW   = 4;
    localparam int MAXV = 15;
    localparam int EW   = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic z = 1'b0;
    logic clear = 1'b0;
    logic rdy = 1'b1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    z_run_monitor_if #(.CNT_W(CW)) if_a ();
    z_run_monitor_if #(.CNT_W(CW)) if_b ();
    assign if_a.out_ready = rdy;
    assign if_b.out_ready = rdy;

    logic [EW-1:0] rc_a, rc_b;
    logic          al_a, al_b, dr_a, dr_b;
`ifdef Z_RUN_MON_MAX_EN
    logic [CW-1:0] mx_a, mx_b;
`endif

    z_run_monitor #(.CNT_W(CW), .EVT_W(EW), .THRESH(5)) dut_a (
        .clk     (clk),
        .rst     (rst),
        .z       (z),
        .clear   (clear),
        .out_if  (if_a),
        .run_cnt (rc_a),
        .alarm   (al_a),
        .drop    (dr_a)
`ifdef Z_RUN_MON_MAX_EN
        ,
        .max_len (mx_a)
`endif
    );

    z_run_monitor #(.CNT_W(CW), .EVT_W(EW), .THRESH(16)) dut_b (
        .clk     (clk),
        .rst     (rst),
        .z       (z),
        .clear   (clear),
        .out_if  (if_b),
        .run_cnt (rc_b),
        .alarm   (al_b),
        .drop    (dr_b)
`ifdef Z_RUN_MON_MAX_EN
        ,
        .max_len (mx_b)
`endif
    );

    // Reference: unsaturated run length as a plain integer; everything else derived from it.
    int run = 0;
    bit m_valid = 0;
    int m_len = 0;
    bit m_sat = 0;
    int m_rc = 0;
    bit m_drop = 0;
    int m_max = 0;
    bit m_al5 = 0;
    bit m_al16 = 0;

    function automatic int clip(input int v);
        return (v > MAXV) ? MAXV : v;
    endfunction

    task automatic model_step();
        bit fin;
        bit lost;
        if (rst) begin
            run = 0; m_valid = 0; m_len = 0; m_sat = 0; m_rc = 0;
            m_drop = 0; m_max = 0; m_al5 = 0; m_al16 = 0;
        end else begin
            fin  = (run > 0) && !z;
            lost = 0;
            m_al5  = z && (clip(run + 1) >= 5);
            m_al16 = z && (clip(run + 1) >= 16);
            if (fin) begin
                if (!m_valid || rdy) begin
                    m_valid = 1; m_len = clip(run); m_sat = (run > MAXV);
                end else begin
                    lost = 1;
                end
            end else if (m_valid && rdy) begin
                m_valid = 0;
            end
            m_rc   = clear ? 0 : (m_rc + int'(fin)) % (1 << EW);
            m_drop = clear ? 0 : (m_drop | lost);
            if (clear) m_max = 0;
            else if (fin && clip(run) > m_max) m_max = clip(run);
            run = z ? run + 1 : 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a_valid", 32'(if_a.out_valid), 32'(m_valid));
        chk("a_len",   32'(if_a.out_len),   32'(m_len));
        chk("a_sat",   32'(if_a.out_sat),   32'(m_sat));
        chk("a_runcnt", 32'(rc_a), 32'(m_rc));
        chk("a_drop",  32'(dr_a), 32'(m_drop));
        chk("a_alarm", 32'(al_a), 32'(m_al5));
        chk("b_valid", 32'(if_b.out_valid), 32'(m_valid));
        chk("b_len",   32'(if_b.out_len),   32'(m_len));
        chk("b_sat",   32'(if_b.out_sat),   32'(m_sat));
        chk("b_runcnt", 32'(rc_b), 32'(m_rc));
        chk("b_drop",  32'(dr_b), 32'(m_drop));
        chk("b_alarm", 32'(al_b), 32'(m_al16));
`ifdef Z_RUN_MON_MAX_EN
        chk("a_maxlen", 32'(mx_a), 32'(m_max));
        chk("b_maxlen", 32'(mx_b), 32'(m_max));
`endif
    endtask

    task automatic cyc(input bit zi, input bit ci, input bit ri);
        z = zi; clear = ci; rdy = ri;
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        chk("reset_valid", 32'(if_a.out_valid), 32'd0);
        rst = 1'b0;

        // 1,1,1,0: record of length 3 one cycle after the first 0.
        cyc(1, 0, 1); cyc(1, 0, 1); cyc(1, 0, 1); cyc(0, 0, 1);
        chk("t1_valid", 32'(if_a.out_valid), 32'd1);
        chk("t1_len",   32'(if_a.out_len),   32'd3);
        chk("t1_runcnt", 32'(rc_a), 32'd1);
        cyc(0, 0, 1);

        // 20-cycle run saturates a 4-bit counter.
        for (int i = 0; i < 20; i++) begin
            cyc(1, 0, 1);
            if (i == 4) chk("alarm_rise_5th", 32'(al_a), 32'd1);
        end
        cyc(0, 0, 1);
        chk("sat_len", 32'(if_a.out_len), 32'd15);
        chk("sat_flag", 32'(if_a.out_sat), 32'd1);
        cyc(0, 1, 1);

        // Held record with ready low: second run is dropped.
        cyc(1, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0);
        cyc(0, 0, 0);
        chk("hold_len", 32'(if_a.out_len), 32'd2);
        chk("hold_drop", 32'(dr_a), 32'd1);
        chk("hold_runcnt", 32'(rc_a), 32'd2);
        cyc(0, 0, 1);
        chk("ready_drains", 32'(if_a.out_valid), 32'd0);
        cyc(0, 1, 1);

        // Back-to-back single-cycle runs with ready held.
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 1); cyc(0, 0, 1);
        end
        chk("alt_runcnt", 32'(rc_a), 32'd4);

        // Reset on the third cycle of a run discards it.
        cyc(1, 0, 1); cyc(1, 0, 1);
        rst = 1'b1; cyc(1, 0, 1); rst = 1'b0;
        cyc(0, 0, 1);
        chk("rst_mid_valid", 32'(if_a.out_valid), 32'd0);

        // Clear coinciding with a run end.
        cyc(1, 0, 1); cyc(1, 0, 1); cyc(0, 1, 1);
        chk("clr_end_runcnt", 32'(rc_a), 32'd0);
        chk("clr_end_valid", 32'(if_a.out_valid), 32'd1);

        // Runs of 3, 7, 2 then clear.
        for (int i = 0; i < 3; i++) cyc(1, 0, 1);
        cyc(0, 0, 1);
        for (int i = 0; i < 7; i++) cyc(1, 0, 1);
        cyc(0, 0, 1);
        for (int i = 0; i < 2; i++) cyc(1, 0, 1);
        cyc(0, 0, 1);
        cyc(0, 1, 1);

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7);
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
